// File: rtl/light_timing_sched.sv
// Timing scheduler for the two-way traffic-light FSM.
// It generates the phase tick and owns the green, yellow and red durations.
// The user edits shadow copies of the durations with sw and the two buttons.
// Edited values reach the light FSM only at an all-red tick boundary.
//
// Commit handshake (valid/ack):
//   cfg_valid rises in the cycle dur_* take the new values.
//   It stays high, with light_hold, until cfg_ack is sampled high on a rising
//   clk edge while cfg_valid=1; that edge completes the transfer.
//   cfg_ack has no effect while cfg_valid is low.
//   There is no timeout.
module light_timing_sched #(
   parameter int TICK_DIV = 125000000,
   parameter int DUR_W    = 3,
   parameter int DEF_G    = 4,
   parameter int DEF_Y    = 1,
   parameter int DEF_R    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       sw,
   input  logic             btn_inc,
   input  logic             btn_dec,
   input  logic             light_allred,
   input  logic             cfg_ack,
   output logic             tick,
   output logic [DUR_W-1:0] dur_g,
   output logic [DUR_W-1:0] dur_y,
   output logic [DUR_W-1:0] dur_r,
   output logic             cfg_valid,
   output logic             light_hold,
   output logic             pending,
   output logic [3:0]       led,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_EDIT      = 2'd1,
      S_WAIT_SAFE = 2'd2,
      S_APPLY     = 2'd3
   } state_t;

   localparam int               CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
   localparam logic [DUR_W-1:0] DUR_MAX = '1;
   localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             btn_inc_q, btn_dec_q;
   logic             inc_press, dec_press, inc_only, dec_only;
   logic [DUR_W-1:0] sh_g, sh_y, sh_r;
   logic             dirty;

   // Saturating step.
   // A value never goes above DUR_MAX or below 1, so 0 is never stored.
   function automatic logic [DUR_W-1:0] bump(input logic [DUR_W-1:0] v,
                                             input logic up, input logic dn);
      logic [DUR_W-1:0] r;
      r = v;
      if (up && (v != DUR_MAX))
         r = v + DUR_ONE;
      else if (dn && (v > DUR_ONE))
         r = v - DUR_ONE;
      return r;
   endfunction

   // Free-running phase divider.
   // It runs in every state and is never stalled by editing.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (cnt == CNT_MAX)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

   assign tick = (cnt == CNT_MAX);

   // Previous button levels.
   // A held level counts as a single press.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_inc_q <= 1'b0;
         btn_dec_q <= 1'b0;
      end else begin
         btn_inc_q <= btn_inc;
         btn_dec_q <= btn_dec;
      end
   end

   assign inc_press = btn_inc & ~btn_inc_q;
   assign dec_press = btn_dec & ~btn_dec_q;
   assign inc_only  = inc_press & ~dec_press;
   assign dec_only  = dec_press & ~inc_press;

   // Shadow durations.
   // Only the one selected by sw is edited, and only while in EDIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_g <= DUR_W'(DEF_G);
         sh_y <= DUR_W'(DEF_Y);
         sh_r <= DUR_W'(DEF_R);
      end else if (state == S_EDIT) begin
         case (sw)
            2'b01:   sh_y <= bump(sh_y, inc_only, dec_only);
            2'b10:   sh_g <= bump(sh_g, inc_only, dec_only);
            2'b11:   sh_r <= bump(sh_r, inc_only, dec_only);
            default: ;
         endcase
      end
   end

   // Active durations.
   // They load only on the edge that enters APPLY.
   always_ff @(posedge clk) begin
      if (rst) begin
         dur_g <= DUR_W'(DEF_G);
         dur_y <= DUR_W'(DEF_Y);
         dur_r <= DUR_W'(DEF_R);
      end else if ((state == S_WAIT_SAFE) && (state_nxt == S_APPLY)) begin
         dur_g <= sh_g;
         dur_y <= sh_y;
         dur_r <= sh_r;
      end
   end

   assign dirty = (sh_g != dur_g) | (sh_y != dur_y) | (sh_r != dur_r);

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic.
   // The light FSM is only touched at an all-red tick boundary.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (sw != 2'b00) state_nxt = S_EDIT;
         S_EDIT:
            if (sw == 2'b00) state_nxt = dirty ? S_WAIT_SAFE : S_IDLE;
         S_WAIT_SAFE:
            if (sw != 2'b00)
               state_nxt = S_EDIT;
            else if (light_allred && tick)
               state_nxt = S_APPLY;
         S_APPLY:
            if (cfg_ack) state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   // Moore outputs.
   // led shows the selected shadow while editing and all ones while a commit is outstanding.
   always_comb begin
      cfg_valid  = 1'b0;
      light_hold = 1'b0;
      pending    = 1'b0;
      led        = 4'b0000;
      state_dbg  = state;
      case (state)
         S_EDIT: begin
            case (sw)
               2'b01:   led = 4'(sh_y);
               2'b10:   led = 4'(sh_g);
               2'b11:   led = 4'(sh_r);
               default: led = 4'b0000;
            endcase
         end
         S_WAIT_SAFE: begin
            pending = 1'b1;
            led     = 4'b1111;
         end
         S_APPLY: begin
            pending    = 1'b1;
            cfg_valid  = 1'b1;
            light_hold = 1'b1;
            led        = 4'b1111;
         end
         default: ;
      endcase
   end

endmodule
